// File: rtl/msk_block_loader.sv
// msk_block_loader
//
// Masked input loader. Collects NWORDS masked words, each WORD bits with d
// shares, over a valid/ready handshake. It packs them into one block register
// of BLK*d bits (BLK = WORD*NWORDS) and holds that block until the downstream
// permutation datapath takes it.
//
// Masking: shares are only muxed and registered. No bit of one share ever
// reaches logic belonging to another share.
//
// Handshake rule, used on both sides: a beat moves on a rising edge where
// valid and ready are both 1. in_ready and out_valid are decoded from the
// registered FSM state only, so neither has a combinational path from
// in_valid or out_ready.
//
// Optional feature, macro MSK_LOADER_PAD_EN: an in_last word closes the block
// early. The unused upper slots are zero-filled and out_nwords reports the
// real word count.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_data    masked word; bit i, share j at index i*d+j
//   in_valid   in_data valid
//   in_last    final word of a message (only used with MSK_LOADER_PAD_EN)
//   in_ready   loader accepts a word this cycle (LOAD state)
//   out_data   masked block; word k at [k*WORD*d +: WORD*d], direct from registers
//   out_nwords number of real (non-padded) words in out_data
//   out_valid  out_data holds a complete block (FULL state)
//   out_ready  consumer takes the block
//   state_dbg  FSM state for checkers (0 = LOAD, 1 = FULL)
module msk_block_loader #(
    parameter int d      = 2,
    parameter int WORD   = 32,
    parameter int NWORDS = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [WORD*d-1:0]               in_data,
    input  logic                            in_valid,
    input  logic                            in_last,
    output logic                            in_ready,
    output logic [WORD*NWORDS*d-1:0]        out_data,
    output logic [$clog2(NWORDS+1)-1:0]     out_nwords,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            state_dbg
);

    localparam int SW = WORD * d;
    localparam int CW = $clog2(NWORDS + 1);

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [CW-1:0]  cnt;
    logic           xfer;
    logic           done;
    logic           early;

`ifdef MSK_LOADER_PAD_EN
    assign early = in_last;
`else
    // in_last has no function without padding support.
    logic unused_last;
    assign unused_last = in_last;
    assign early       = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        xfer      = 1'b0;
        done      = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                xfer     = in_valid;
                if (in_valid && ((cnt == CW'(NWORDS - 1)) || early)) begin
                    done    = 1'b1;
                    state_n = FULL;
                end
            end
            FULL: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_n = LOAD;
                end
            end
            default: state_n = LOAD;
        endcase
    end

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            cnt        <= '0;
            out_data   <= '0;
            out_nwords <= '0;
        end else begin
            state <= state_n;
            if (xfer) begin
                cnt <= done ? '0 : cnt + 1'b1;
            end
            // Each slot has its own enable; only the addressed slot loads.
            // Slots left untouched keep old words until they are overwritten.
            for (int k = 0; k < NWORDS; k++) begin
                if (xfer && (cnt == CW'(k))) begin
                    out_data[k*SW +: SW] <= in_data;
`ifdef MSK_LOADER_PAD_EN
                end else if (done && early && (CW'(k) > cnt)) begin
                    // Early close: fill the unused slots with an all-zero sharing.
                    out_data[k*SW +: SW] <= '0;
`endif
                end
            end
            if (done) begin
`ifdef MSK_LOADER_PAD_EN
                out_nwords <= cnt + 1'b1;
`else
                out_nwords <= CW'(NWORDS);
`endif
            end
        end
    end

endmodule

// File: doc/msk_block_loader.md
# msk_block_loader

Masked input loader that collects a stream of `d`-share masked words over a valid/ready handshake and packs them into one full-width masked block register. It sits directly upstream of the masked state registers of the AEAD core. Once `NWORDS` words are held, it presents the complete sharing to the permutation datapath and holds it until that datapath acknowledges. Shares are only ever moved and held, never combined, so the block adds no leakage.

## Interface
Parameters:
- `d`, default 2: number of shares per bit.
- `WORD`, default 32: bits per input word.
- `NWORDS`, default 4: words per block, at least 2. Block width is `BLK = WORD*NWORDS`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_data`, input, `WORD*d`: masked word. Bit `i`, share `j` is at index `i*d+j`.
- `in_valid`, input, 1: `in_data` is valid.
- `in_last`, input, 1: marks the final word of a message. Used only with `MSK_LOADER_PAD_EN`.
- `in_ready`, output, 1: the loader accepts a word this cycle.
- `out_data`, output, `BLK*d`: masked block. Word `k` occupies bits `[k*WORD*d +: WORD*d]`.
- `out_nwords`, output, `$clog2(NWORDS+1)`: number of real (non-padded) words in `out_data`.
- `out_valid`, output, 1: `out_data` holds a complete block.
- `out_ready`, input, 1: the consumer takes the block.

## Operation
- Two-state FSM: `LOAD` and `FULL`.
- Reset forces `LOAD` with word counter `cnt = 0`.
  - Reset values: `out_data` all zero, `out_nwords = 0`, `out_valid = 0`, `in_ready = 1` on the first cycle after reset.
- **LOAD state**
  - `in_ready = 1`.
  - A transfer occurs when `in_valid & in_ready`. On a transfer, `in_data` is written into word slot `cnt` and `cnt` increments.
  - All other slots hold their value through enable-gated registers; no unused slot is updated.
  - A transfer when `cnt == NWORDS-1` moves the FSM to `FULL`, resets `cnt` to 0 and sets `out_nwords = NWORDS`.
- **FULL state**
  - `in_ready = 0` and `out_valid = 1`.
  - `out_data` is stable and driven directly from registers, with no combinational logic between the registers and the port.
  - `out_valid & out_ready` returns the FSM to `LOAD`.
  - `out_data` is retained, not cleared, on that return. It keeps old words until they are overwritten.
- `in_valid` while in `FULL` is ignored, with no data loss: the producer holds the word because `in_ready = 0`.
- Share handling:
  - No bit of one share ever feeds logic of another share.
  - Only muxing and registering are applied.
- `cnt` never exceeds `NWORDS-1`; there is no wrap other than the reset to 0 on entering `FULL`.

## Timing
- Latency: `out_valid` rises in the cycle after the `NWORDS`-th accepted transfer.
- Minimum block period: `NWORDS+1` cycles (NWORDS transfers, then one handshake cycle).
  - If `out_ready` is held at 1, `in_ready` returns to 1 in the cycle after `FULL`.
- `in_ready` and `out_valid` are decoded from registered FSM state only. Neither has a combinational path from `in_valid` or `out_ready`.
- A reset asserted mid-block, in either state, discards the partial block. Reset values apply in the next cycle, and the same-cycle transfer or handshake is ignored.

## Configuration
- Macro: `MSK_LOADER_PAD_EN`.
- **Defined:**
  - A transfer with `in_last = 1` in slot `cnt < NWORDS-1` completes the block early and moves the FSM to `FULL`.
  - All slots above `cnt` are written with all-zero sharings in that same edge.
  - `out_nwords = cnt + 1`.
  - `in_last` on slot `NWORDS-1` behaves as a normal full block.
- **Undefined:**
  - `in_last` is ignored and the padding logic is not built.
  - Every block is exactly `NWORDS` words, and `out_nwords` is constant `NWORDS` after the first block.

## Test plan
- **Reset values.** Reset for 2 cycles, then release → `out_valid = 0`, `in_ready = 1`, `out_data = 0`, `out_nwords = 0`.
- **Full block.** `d = 2`, `NWORDS = 4`. Stream 4 words with share0 = `A_k`, share1 = `A_k ^ 0x1234567k`, `in_valid` always 1, `out_ready = 1` → `out_valid` for exactly 1 cycle, 1 cycle after the 4th transfer. Recombined words equal `0x1234567k` in slots 0..3, and `out_nwords = 4`.
- **Backpressure.** Hold `out_ready = 0` for 5 cycles while `in_valid = 1` → `in_ready = 0` and `out_data` unchanged throughout. Raising `out_ready` → exactly 1 handshake, then the next word is accepted into slot 0.
- **Gapped input.** Toggle `in_valid` 1,0,1,0,... → only accepted words advance `cnt`, and the block completes after 4 accepts (8 cycles).
- **Mid-block reset.** Assert `rst` after 2 transfers → reset values in the next cycle. A new 4-word block is then assembled from slot 0 with no stale words.
- **Padding.** With `MSK_LOADER_PAD_EN`, send 2 words with `in_last` on the 2nd → `FULL` on the next cycle, slots 2..3 all zero in every share, `out_nwords = 2`. Without the macro, the same stimulus waits for 2 more words.
